sim_run_ctrl: RTL and testbench
===============================

SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 5, meaning the number of cycles o_soc_reset is held after each (re)start; legal range 1..65535.
REQ-002 SHALL have parameter MAX_RUNS, default 2, meaning the number of shutdown-terminated runs before done; legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 20000000, meaning the per-run cycle limit; 0 disables the timeout.
REQ-004 SHALL have parameter CNT_W, default 32, meaning the width of the cycle counter; 2**CNT_W > TIMEOUT_CYCLES.
REQ-005 i_clk  input  1  sole clock, all logic on rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_shutdown  input  1  level shutdown request from the SoC.
REQ-008 o_soc_reset  output  1  synchronous active-high reset to the SoC.
REQ-009 o_running  output  1  high while in RUN.
REQ-010 o_done  output  1  sticky: MAX_RUNS runs completed by shutdown.
REQ-011 o_timeout  output  1  sticky: a run hit TIMEOUT_CYCLES.
REQ-012 o_run_count  output  RW=$clog2(MAX_RUNS+1)  number of completed runs.
REQ-013 o_cycle_count  output  CNT_W  cycles elapsed in the current or last run.

Function
REQ-014 SHALL implement FSM states HOLD, RUN, DONE, TIMEOUT; all outputs registered, decoded from state and counters with no combinational path from i_shutdown.
REQ-015 HOLD: o_soc_reset=1; a hold counter loads RESET_CYCLES-1 on entry and decrements; at 0 the next state is RUN, so o_soc_reset stays high for exactly RESET_CYCLES cycles.
REQ-016 RUN: o_soc_reset=0, o_running=1; o_cycle_count starts at 0 on the first RUN cycle and increments by 1 each RUN cycle.
REQ-017 RUN with i_shutdown=1: o_run_count increments; if the new count equals MAX_RUNS, next state is DONE, otherwise next state is HOLD (restart); o_cycle_count freezes at its value in that cycle.
REQ-018 RUN with TIMEOUT_CYCLES!=0 and o_cycle_count==TIMEOUT_CYCLES-1 with i_shutdown=0: next state is TIMEOUT.
REQ-019 Shutdown and timeout in the same cycle: shutdown wins; o_timeout remains 0.
REQ-020 i_shutdown SHALL be ignored in HOLD, DONE and TIMEOUT; a level still high on the first RUN cycle counts as a new shutdown.
REQ-021 DONE and TIMEOUT are terminal: o_soc_reset=1, o_running=0, counters frozen; exited only by i_reset.
REQ-022 o_cycle_count SHALL saturate at 2**CNT_W-1 when the timeout is disabled; it never wraps.
REQ-023 o_run_count SHALL never exceed MAX_RUNS.

Reset
REQ-024 i_reset=1 at a rising edge SHALL, regardless of state, force HOLD with the hold counter reloaded, o_soc_reset=1, o_running=0, o_done=0, o_timeout=0, o_run_count=0, o_cycle_count=0.
REQ-025 After i_reset falls, o_soc_reset SHALL remain high for RESET_CYCLES further cycles; i_reset asserted mid-RUN aborts the run without incrementing o_run_count.

Structure
REQ-026 State encoding localparams and the RW width function SHALL live in the shared sim package soc_sim_pkg.
REQ-027 Hold countdown SHALL use one sub-module ld_down_counter (load, enable, zero flag); the cycle counter stays inline.
REQ-028 Block SHALL be synthesizable (no delays, no system tasks) so that both tb_top and FPGA tops instantiate it; $finish stays in the bench, keyed on o_done or o_timeout.

Verification
REQ-029 Defaults, i_reset high for 3 cycles, i_shutdown pulse on RUN cycle 100 -> o_soc_reset high for 5 cycles, then RUN; o_run_count=1, o_cycle_count=100 frozen during HOLD; 5 cycles later RUN again.
REQ-030 MAX_RUNS=2, second shutdown at RUN cycle 40 -> o_done=1, o_run_count=2, o_soc_reset=1, state stays DONE for 1000 cycles with i_shutdown toggling.
REQ-031 TIMEOUT_CYCLES=50, no shutdown -> o_timeout=1 after cycle_count 49, o_run_count=0, o_done=0.
REQ-032 TIMEOUT_CYCLES=50, i_shutdown high on cycle_count 49 -> restart into HOLD, o_timeout=0, o_run_count=1.
REQ-033 i_shutdown held high continuously, MAX_RUNS=3, RESET_CYCLES=1 -> each RUN lasts 1 cycle, o_done after 3 runs, o_cycle_count=0.
REQ-034 i_reset pulsed during RUN cycle 20 of run 2 -> all outputs return to reset values, o_run_count=0, 5-cycle hold reapplied.

Source files
------------

// File: rtl/soc_sim_pkg.sv
// Shared definitions for the simulation run controller: state encoding,
// hold counter width and the run-count width helper.
package soc_sim_pkg;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    HOLD    = ST_HOLD,
    RUN     = ST_RUN,
    DONE    = ST_DONE,
    TIMEOUT = ST_TIMEOUT
  } run_state_e;

  // Wide enough for any legal RESET_CYCLES (1..65535).
  localparam int HOLD_W = 16;

  function automatic int run_w(input int max_runs);
    return $clog2(max_runs + 1);
  endfunction

endpackage

// File: rtl/ld_down_counter.sv
// Loadable down counter that stops at zero; used for the SoC reset hold time.
module ld_down_counter
  import soc_sim_pkg::*;
#(
  parameter int W = HOLD_W
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: no reset of its own; the owner asserts load during its reset, so
  // the count is defined from the first edge after reset and beyond.
  always_ff @(posedge clk) begin
    if (load)
      count <= load_value;
    else if (en && !zero)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: holds the SoC in reset, lets it run until it
// requests shutdown (restarting up to MAX_RUNS times) or hits a cycle limit.
module sim_run_ctrl
  import soc_sim_pkg::*;
#(
  parameter int          RESET_CYCLES   = 5,
  parameter int          MAX_RUNS       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 20000000,
  parameter int          CNT_W          = 32,
  localparam int         RW             = run_w(MAX_RUNS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_shutdown,
  output logic             o_soc_reset,
  output logic             o_running,
  output logic             o_done,
  output logic             o_timeout,
  output logic [RW-1:0]    o_run_count,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [RW-1:0]     LAST_RUN  = RW'(MAX_RUNS - 1);
  localparam logic              TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  TO_LAST   = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  run_state_e        state;
  logic              soc_reset_q;
  logic              running_q;
  logic              done_q;
  logic              timeout_q;
  logic [RW-1:0]     run_count_q;
  logic [CNT_W-1:0]  cycle_count_q;

  logic              hold_load;
  logic              hold_en;
  logic              hold_zero;
  logic [HOLD_W-1:0] hold_count;
  logic              last_run;
  logic              timeout_hit;

  assign last_run    = (run_count_q == LAST_RUN);
  assign timeout_hit = TO_EN && (cycle_count_q == TO_LAST);

  // Reload on reset and on every restart so each hold lasts RESET_CYCLES.
  assign hold_load = i_reset || (state == RUN && i_shutdown && !last_run);
  assign hold_en   = (state == HOLD);

  ld_down_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk        (i_clk),
    .load       (hold_load),
    .load_value (HOLD_LOAD),
    .en         (hold_en),
    .count      (hold_count),
    .zero       (hold_zero)
  );

  // NOTE: state and every output are updated with <= in one clocked block,
  // so outputs are registered and i_shutdown never reaches a port directly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= HOLD;
      soc_reset_q   <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      run_count_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_zero) begin
            state         <= RUN;
            soc_reset_q   <= 1'b0;
            running_q     <= 1'b1;
            cycle_count_q <= '0;
          end
        end
        RUN: begin
          // Shutdown takes priority over a coincident timeout.
          if (i_shutdown) begin
            run_count_q <= run_count_q + RW'(1);
            soc_reset_q <= 1'b1;
            running_q   <= 1'b0;
            if (last_run) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end else if (timeout_hit) begin
            state       <= TIMEOUT;
            timeout_q   <= 1'b1;
            soc_reset_q <= 1'b1;
            running_q   <= 1'b0;
          end else if (cycle_count_q != '1) begin
            cycle_count_q <= cycle_count_q + CNT_W'(1);
          end
        end
        DONE, TIMEOUT: begin
          state <= state;
        end
        default: begin
          state       <= HOLD;
          soc_reset_q <= 1'b1;
          running_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_soc_reset   = soc_reset_q;
  assign o_running     = running_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_run_count   = run_count_q;
  assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: four instances cover the default setup,
// a short timeout, back-to-back one-cycle runs and counter saturation.
module tb_sim_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // a: defaults
  logic a_reset, a_shdn, a_sr, a_run, a_done, a_to;
  logic [1:0]  a_rc;
  logic [31:0] a_cc;
  // b: 50-cycle timeout
  logic b_reset, b_shdn, b_sr, b_run, b_done, b_to;
  logic [1:0]  b_rc;
  logic [31:0] b_cc;
  // c: three runs, one-cycle hold
  logic c_reset, c_shdn, c_sr, c_run, c_done, c_to;
  logic [1:0]  c_rc;
  logic [31:0] c_cc;
  // d: 4-bit counter, timeout disabled, single run
  logic d_reset, d_shdn, d_sr, d_run, d_done, d_to;
  logic [0:0]  d_rc;
  logic [3:0]  d_cc;

  sim_run_ctrl u_a (
    .i_clk(clk), .i_reset(a_reset), .i_shutdown(a_shdn),
    .o_soc_reset(a_sr), .o_running(a_run), .o_done(a_done), .o_timeout(a_to),
    .o_run_count(a_rc), .o_cycle_count(a_cc)
  );

  sim_run_ctrl #(.TIMEOUT_CYCLES(50)) u_b (
    .i_clk(clk), .i_reset(b_reset), .i_shutdown(b_shdn),
    .o_soc_reset(b_sr), .o_running(b_run), .o_done(b_done), .o_timeout(b_to),
    .o_run_count(b_rc), .o_cycle_count(b_cc)
  );

  sim_run_ctrl #(.RESET_CYCLES(1), .MAX_RUNS(3)) u_c (
    .i_clk(clk), .i_reset(c_reset), .i_shutdown(c_shdn),
    .o_soc_reset(c_sr), .o_running(c_run), .o_done(c_done), .o_timeout(c_to),
    .o_run_count(c_rc), .o_cycle_count(c_cc)
  );

  sim_run_ctrl #(.RESET_CYCLES(2), .MAX_RUNS(1), .TIMEOUT_CYCLES(0), .CNT_W(4)) u_d (
    .i_clk(clk), .i_reset(d_reset), .i_shutdown(d_shdn),
    .o_soc_reset(d_sr), .o_running(d_run), .o_done(d_done), .o_timeout(d_to),
    .o_run_count(d_rc), .o_cycle_count(d_cc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_sr(input int sel);
    case (sel)
      0:       return a_sr;
      1:       return b_sr;
      2:       return c_sr;
      default: return d_sr;
    endcase
  endfunction

  // Samples (including the current one) with o_soc_reset high, bounded.
  task automatic hold_len(input int sel, output int n);
    n = 0;
    while (sel_sr(sel) && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, bad, steps, runs;
    a_reset = 1'b1; a_shdn = 1'b0;
    b_reset = 1'b1; b_shdn = 1'b0;
    c_reset = 1'b1; c_shdn = 1'b1;
    d_reset = 1'b1; d_shdn = 1'b0;

    // ---- a: reset, first run, restart, done ----
    repeat (3) tick();
    check("a_rst_soc_reset", a_sr, 1);
    check("a_rst_running",   a_run, 0);
    check("a_rst_done",      a_done, 0);
    check("a_rst_timeout",   a_to, 0);
    check("a_rst_run_count", a_rc, 0);
    check("a_rst_cycles",    a_cc, 0);
    a_reset = 1'b0;
    hold_len(0, n);
    check("a_hold_after_reset", n, 5);
    check("a_run1_running", a_run, 1);
    check("a_run1_cc0", a_cc, 0);
    repeat (100) tick();
    check("a_run1_cc100", a_cc, 100);
    a_shdn = 1'b1; tick(); a_shdn = 1'b0;
    check("a_sd1_run_count", a_rc, 1);
    check("a_sd1_cc_frozen", a_cc, 100);
    check("a_sd1_soc_reset", a_sr, 1);
    check("a_sd1_running",   a_run, 0);
    repeat (3) tick();
    check("a_hold_cc_frozen", a_cc, 100);
    hold_len(0, n);
    check("a_restart_hold_rest", n, 2);
    check("a_run2_running", a_run, 1);
    check("a_run2_cc0", a_cc, 0);
    repeat (40) tick();
    check("a_run2_cc40", a_cc, 40);
    a_shdn = 1'b1; tick(); a_shdn = 1'b0;
    check("a_done_flag", a_done, 1);
    check("a_done_run_count", a_rc, 2);
    check("a_done_soc_reset", a_sr, 1);
    check("a_done_running", a_run, 0);
    check("a_done_cc", a_cc, 40);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a_shdn = (i % 3 == 0);
      tick();
      if (a_run || !a_sr || !a_done) bad++;
    end
    a_shdn = 1'b0;
    check("a_done_stays_bad_cycles", bad, 0);
    check("a_done_hold_run_count", a_rc, 2);
    check("a_done_hold_cc", a_cc, 40);

    // ---- a: reset mid-run 2 ----
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    check("a_rst2_done_cleared", a_done, 0);
    check("a_rst2_run_count", a_rc, 0);
    hold_len(0, n);
    check("a_rst2_hold", n, 5);
    repeat (10) tick();
    a_shdn = 1'b1; tick(); a_shdn = 1'b0;
    hold_len(0, n);
    check("a_r2_restart_hold", n, 5);
    repeat (20) tick();
    check("a_r2_cc20", a_cc, 20);
    check("a_r2_run_count", a_rc, 1);
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    check("a_abort_run_count", a_rc, 0);
    check("a_abort_cc", a_cc, 0);
    check("a_abort_soc_reset", a_sr, 1);
    check("a_abort_running", a_run, 0);
    check("a_abort_timeout", a_to, 0);
    hold_len(0, n);
    check("a_abort_hold", n, 5);
    check("a_abort_rerun", a_run, 1);

    // ---- b: timeout with no shutdown ----
    b_reset = 1'b0;
    hold_len(1, n);
    check("b_hold", n, 5);
    repeat (49) tick();
    check("b_cc49", b_cc, 49);
    check("b_still_running", b_run, 1);
    tick();
    check("b_timeout_flag", b_to, 1);
    check("b_timeout_running", b_run, 0);
    check("b_timeout_soc_reset", b_sr, 1);
    check("b_timeout_run_count", b_rc, 0);
    check("b_timeout_done", b_done, 0);
    check("b_timeout_cc", b_cc, 49);
    for (int i = 0; i < 10; i++) begin
      b_shdn = i[0];
      tick();
    end
    b_shdn = 1'b0;
    check("b_timeout_sticky", b_to, 1);
    check("b_timeout_rc_frozen", b_rc, 0);

    // ---- b: shutdown coincident with timeout ----
    b_reset = 1'b1; tick(); b_reset = 1'b0;
    check("b_rst_timeout_cleared", b_to, 0);
    hold_len(1, n);
    repeat (49) tick();
    check("b2_cc49", b_cc, 49);
    b_shdn = 1'b1; tick(); b_shdn = 1'b0;
    check("b2_no_timeout", b_to, 0);
    check("b2_run_count", b_rc, 1);
    check("b2_soc_reset", b_sr, 1);
    hold_len(1, n);
    check("b2_restart_hold", n, 5);
    check("b2_rerun_cc0", b_cc, 0);

    // ---- c: shutdown held high, one-cycle runs ----
    c_reset = 1'b0;
    steps = 0;
    runs  = 0;
    while (!c_done && steps < 50) begin
      if (c_run) runs++;
      tick();
      steps++;
    end
    check("c_steps_to_done", steps, 6);
    check("c_run_cycles", runs, 3);
    check("c_done_run_count", c_rc, 3);
    check("c_done_cc", c_cc, 0);
    check("c_done_soc_reset", c_sr, 1);
    check("c_no_timeout", c_to, 0);

    // ---- d: saturation with timeout disabled ----
    d_reset = 1'b0;
    hold_len(3, n);
    check("d_hold", n, 2);
    repeat (15) tick();
    check("d_cc15", d_cc, 15);
    repeat (5) tick();
    check("d_cc_saturated", d_cc, 15);
    check("d_still_running", d_run, 1);
    d_shdn = 1'b1; tick(); d_shdn = 1'b0;
    check("d_done", d_done, 1);
    check("d_run_count", d_rc, 1);
    check("d_cc_final", d_cc, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
